// File: rtl/itch_msg_framer_pkg.sv
// Shared definitions for the ITCH length-prefixed message framer.
package itch_pkg;

  localparam int MAX_LEN_DEF = 64;
  localparam int LEN_W_DEF   = 16;

  typedef enum logic [2:0] {
    ST_LEN_HI  = 3'd0,
    ST_LEN_LO  = 3'd1,
    ST_PAYLOAD = 3'd2,
    ST_DROP    = 3'd3,
    ST_GAP     = 3'd4
  } framer_state_t;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/itch_msg_framer_if.sv
// Upstream byte stream with valid/ready handshake.
interface itch_msg_framer_if;
  logic [7:0] s_byte;
  logic       s_valid;
  logic       s_ready;

  modport master (output s_byte, output s_valid, input s_ready);
  modport slave  (input s_byte, input s_valid, output s_ready);
endinterface

// File: rtl/itch_msg_framer.sv
// Splits a stream of 2-byte big-endian length prefixes plus payloads into
// framed payload bytes with start/end markers; oversize messages are dropped.
module itch_msg_framer
  import itch_pkg::*;
#(
  parameter int MAX_LEN = MAX_LEN_DEF,
  parameter int LEN_W   = LEN_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  itch_msg_framer_if.slave  s,
  output logic [7:0]        byte_out,
  output logic              valid_out,
  output logic              msg_start,
  output logic              msg_end,
  output logic              len_error,
  output logic [31:0]       msg_count,
  output logic [15:0]       err_count
);

  framer_state_t    state;
  logic [7:0]       len_hi;
  logic [LEN_W-1:0] rem;
  logic             first;
  logic             ready_en;

  logic [15:0] len_word;
  logic        accept;
  logic        oversize;
  logic        rem_last;
  logic        payload_take;
  logic        payload_last;
  logic        lo_drop;

  assign len_word     = {len_hi, s.s_byte};
  assign oversize     = len_word > 16'(MAX_LEN);
  assign rem_last     = (rem == LEN_W'(1));
  assign accept       = s.s_valid && s.s_ready;
  assign payload_take = accept && (state == ST_PAYLOAD);
  assign payload_last = payload_take && rem_last;
  assign lo_drop      = accept && (state == ST_LEN_LO) && oversize;

  // Ready stays low during reset and comes up on the first edge after release;
  // the single GAP cycle also blocks the upstream.
  assign s.s_ready = ready_en && (state != ST_GAP);

  // Gate that opens ready one clock after reset release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ready_en <= 1'b0;
    else      ready_en <= 1'b1;
  end

  // Framing state machine with remaining-byte counter; idle upstream cycles hold everything.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= ST_LEN_HI;
      len_hi <= 8'h00;
      rem    <= '0;
      first  <= 1'b0;
    end else begin
      case (state)
        ST_LEN_HI: if (accept) begin
          len_hi <= s.s_byte;
          state  <= ST_LEN_LO;
        end
        ST_LEN_LO: if (accept) begin
          rem <= LEN_W'(len_word);
          if (len_word == 16'd0) begin
            state <= ST_LEN_HI;            // heartbeat: nothing to frame
          end else if (oversize) begin
            state <= ST_DROP;
          end else begin
            state <= ST_PAYLOAD;
            first <= 1'b1;
          end
        end
        ST_PAYLOAD: if (accept) begin
          first <= 1'b0;
          rem   <= rem - LEN_W'(1);
          if (rem_last) state <= ST_GAP;
        end
        ST_DROP: if (accept) begin
          rem <= rem - LEN_W'(1);
          if (rem_last) state <= ST_LEN_HI;
        end
        ST_GAP:  state <= ST_LEN_HI;
        default: state <= ST_LEN_HI;
      endcase
    end
  end

  // Registered payload output and single-cycle event pulses; byte_out holds when idle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      byte_out  <= 8'h00;
      valid_out <= 1'b0;
      msg_start <= 1'b0;
      msg_end   <= 1'b0;
      len_error <= 1'b0;
    end else begin
      valid_out <= payload_take;
      msg_start <= payload_take && first;
      msg_end   <= payload_last;
      len_error <= lo_drop;
      if (payload_take) byte_out <= s.s_byte;
    end
  end

  // Statistics: forwarded messages wrap, dropped messages saturate.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      msg_count <= 32'd0;
      err_count <= 16'd0;
    end else begin
      if (payload_last) msg_count <= msg_count + 32'd1;
      if (lo_drop)      err_count <= sat_inc16(err_count);
    end
  end

endmodule

// File: doc/itch_msg_framer.md
ITCH_MSG_FRAMER -- requirements
Module: itch_msg_framer

Interface
REQ-001 Parameter MAX_LEN, default 64, largest accepted message length in bytes; longer messages are dropped.
REQ-002 Parameter LEN_W, default 16, width of the length prefix and length counters.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low (asserted at 0).
REQ-005 s_byte  input  8  upstream stream byte: 2-byte big-endian length prefix, then payload, repeating.
REQ-006 s_valid  input  1  s_byte valid; a byte transfers when s_valid and s_ready are both 1.
REQ-007 s_ready  output  1  framer can accept a byte this cycle.
REQ-008 byte_out  output  8  payload byte to the message decoders.
REQ-009 valid_out  output  1  byte_out valid; drives decoder valid_in.
REQ-010 msg_start  output  1  pulse with the first payload byte of a message.
REQ-011 msg_end  output  1  pulse with the last payload byte of a message.
REQ-012 len_error  output  1  one-cycle pulse when an oversize length is latched.
REQ-013 msg_count  output  32  count of messages fully forwarded, wraps at 2^32.
REQ-014 err_count  output  16  count of dropped oversize messages, saturates at 0xFFFF.

Function
REQ-015 States: LEN_HI, LEN_LO, PAYLOAD, DROP, GAP; reset state LEN_HI.
REQ-016 LEN_HI: accepted byte -> len[15:8]; next LEN_LO.
REQ-017 LEN_LO: accepted byte -> len[7:0]; len==0 -> LEN_HI (heartbeat, no output, no error); len>MAX_LEN -> DROP with len_error pulse next cycle; else -> PAYLOAD.
REQ-018 PAYLOAD: each accepted byte registered to byte_out with valid_out=1 one cycle later (latency 1); remaining counter decrements; last byte -> GAP.
REQ-019 msg_start asserted with first payload byte's valid_out; msg_end with last; both asserted together when len==1.
REQ-020 DROP: accept and discard len bytes, valid_out=0 throughout; after last byte -> LEN_HI; err_count +1 (saturating) on DROP entry.
REQ-021 GAP: exactly one cycle, s_ready=0, valid_out=0, then LEN_HI; guarantees decoders see valid_in low between messages.
REQ-022 s_ready=1 in LEN_HI, LEN_LO, PAYLOAD, DROP; 0 in GAP.
REQ-023 s_valid=0 mid-message: state and counters hold; valid_out=0 that cycle; message resumes without loss.
REQ-024 msg_count increments in the cycle msg_end is asserted.
REQ-025 len==MAX_LEN is accepted; len==MAX_LEN+1 is dropped.
REQ-026 valid_out, msg_start, msg_end, len_error only ever high for one cycle per event; byte_out holds last value when valid_out=0.

Reset
REQ-027 rst=0 asynchronously forces state LEN_HI, remaining counter 0, byte_out 0x00, valid_out/msg_start/msg_end/len_error 0, msg_count 0, err_count 0.
REQ-028 s_ready is 0 while rst=0 and 1 from the first clk edge after deassertion.
REQ-029 Reset mid-message discards the partial message; no msg_end, no count change; next byte after release is treated as LEN_HI.

Structure
REQ-030 Shared package itch_pkg holds the framer state enum, MAX_LEN default and LEN_W default.
REQ-031 Single module, no sub-modules; counters and FSM inline.

Verification
REQ-032 Stream 00 01 'A' -> one valid_out cycle byte_out=0x41, msg_start=msg_end=1, msg_count=1.
REQ-033 Stream 00 24 + 36-byte add-order payload then 00 13 + 19-byte cancel payload, s_valid continuous -> 36 then 19 valid_out cycles, one-cycle gap between, msg_count=2, no error.
REQ-034 Stream 00 41 (65 bytes) + 65 bytes then 00 02 AA BB -> len_error pulse, err_count=1, no valid_out for first 65, then AA BB forwarded, msg_count=1.
REQ-035 Stream 00 00 then 00 01 55 -> heartbeat silent, 0x55 forwarded, err_count=0.
REQ-036 Random s_valid gaps (50%) over 00 08 + 8 bytes -> same 8 bytes in order, msg_start on first, msg_end on eighth.
REQ-037 rst=0 after 3 payload bytes of a 10-byte message, release, send 00 02 01 02 -> outputs reset immediately, then 01 02 forwarded, msg_count=1.
